// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared defaults, clog2 and even-parity helpers for sync_fifo
package sync_fifo_pkg;
  localparam int DEF_DATASIZE  = 8;
  localparam int DEF_MEM_DEPTH = 16;
  localparam int DEF_ADDRSIZE  = 4;
  localparam int DEF_AF_THRESH = 12;
  localparam int DEF_AE_THRESH = 2;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction
  function automatic logic even_par(input logic [63:0] v);
    return ^v;
  endfunction
endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: 1-write/1-read synchronous array, registered read port, no reset
module sync_fifo_ram #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;
  assign rdata_o = rdata_q;
  // write port and registered read port; read data holds when not reading
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: parametrised single-clock FIFO with registered flags; SYNC_FIFO_PARITY_EN adds parity and o_par_err
module sync_fifo import sync_fifo_pkg::*; #(
  parameter int DATASIZE  = DEF_DATASIZE,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int ADDRSIZE  = DEF_ADDRSIZE,
  parameter int AF_THRESH = DEF_AF_THRESH,
  parameter int AE_THRESH = DEF_AE_THRESH
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_clr,
  input  logic                i_wr_en,
  input  logic [DATASIZE-1:0] i_wr_data,
  input  logic                i_rd_en,
  output logic [DATASIZE-1:0] o_rd_data,
  output logic                o_rd_valid,
  output logic                o_full,
  output logic                o_empty,
  output logic                o_afull,
  output logic                o_aempty,
  output logic [ADDRSIZE:0]   o_count,
  output logic                o_ovf,
  output logic                o_udf
`ifdef SYNC_FIFO_PARITY_EN
  ,output logic               o_par_err
`endif
);
  if (ADDRSIZE != clog2(MEM_DEPTH)) begin : g_bad_addrsize
    $error("sync_fifo: ADDRSIZE must equal clog2(MEM_DEPTH)");
  end
  typedef logic [ADDRSIZE-1:0] ptr_t;
  typedef logic [ADDRSIZE:0] cnt_t;
  localparam ptr_t LAST    = ptr_t'(MEM_DEPTH - 1);
  localparam cnt_t DEPTH_C = cnt_t'(MEM_DEPTH);
  localparam cnt_t AF_C    = cnt_t'(AF_THRESH);
  localparam cnt_t AE_C    = cnt_t'(AE_THRESH);
`ifdef SYNC_FIFO_PARITY_EN
  localparam int MW = DATASIZE + 1;
`else
  localparam int MW = DATASIZE;
`endif
  ptr_t wptr_q, wptr_d, rptr_q, rptr_d;
  cnt_t count_q, count_d;
  logic wr_acc, rd_acc, we, re;
  logic full_q, empty_q, afull_q, aempty_q, ovf_q, udf_q, rd_valid_q, rd_seen_q;
  logic [MW-1:0] wword, rword;
  // accept on registered flags; flush suppresses both ports
  always_comb begin
    wr_acc  = i_wr_en & ~full_q;
    rd_acc  = i_rd_en & ~empty_q;
    we      = wr_acc & ~i_clr;
    re      = rd_acc & ~i_clr;
    wptr_d  = i_clr ? '0 : we ? ((wptr_q == LAST) ? '0 : wptr_q + 1'b1) : wptr_q;
    rptr_d  = i_clr ? '0 : re ? ((rptr_q == LAST) ? '0 : rptr_q + 1'b1) : rptr_q;
    count_d = i_clr ? '0 : (we & ~re) ? count_q + 1'b1 : (re & ~we) ? count_q - 1'b1 : count_q;
  end
  // state and flags, all flags taken from the next count so they track o_count
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_seen_q  <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      full_q     <= count_d == DEPTH_C;
      empty_q    <= count_d == '0;
      afull_q    <= count_d >= AF_C;
      aempty_q   <= count_d <= AE_C;
      ovf_q      <= ~i_clr & (ovf_q | (i_wr_en & full_q));
      udf_q      <= ~i_clr & (udf_q | (i_rd_en & empty_q));
      rd_valid_q <= re;
      rd_seen_q  <= rd_seen_q | re;
    end
  end
`ifdef SYNC_FIFO_PARITY_EN
  assign wword     = {even_par(64'(i_wr_data)), i_wr_data};
  assign o_par_err = rd_valid_q & (^rword);
`else
  assign wword = i_wr_data;
`endif
  sync_fifo_ram #(.W(MW), .DEPTH(MEM_DEPTH), .AW(ADDRSIZE)) u_ram (
    .clk_i  (i_clk),
    .we_i   (we),
    .waddr_i(wptr_q),
    .wdata_i(wword),
    .re_i   (re),
    .raddr_i(rptr_q),
    .rdata_o(rword)
  );
  // the unreset array output is masked to zero until the first pop
  assign o_rd_data  = rd_seen_q ? rword[DATASIZE-1:0] : '0;
  assign o_rd_valid = rd_valid_q;
  assign o_full     = full_q;
  assign o_empty    = empty_q;
  assign o_afull    = afull_q;
  assign o_aempty   = aempty_q;
  assign o_count    = count_q;
  assign o_ovf      = ovf_q;
  assign o_udf      = udf_q;
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: random and directed checks of two sync_fifo sizes against a queue model
module tb_sync_fifo;
  localparam int DEPTH [2] = '{16, 10};
  localparam int AFTH  [2] = '{12, 7};
  localparam int AETH = 2;
  logic clk = 0, rst = 0, clr = 0, wr = 0, rd = 0;
  logic [7:0] wd = 0;
  logic [7:0] rdata [2];
  logic [4:0] cnt [2];
  logic rvalid [2], full [2], empty [2], afull [2], aempty [2], ovf [2], udf [2];
`ifdef SYNC_FIFO_PARITY_EN
  logic perr [2];
`endif
  int errors = 0, checks = 0;
  bit chk_on = 0;
  logic [7:0] mq [2][$];
  logic [7:0] m_data [2];
  bit m_valid [2], m_ovf [2], m_udf [2];
  always #5 clk = ~clk;
  sync_fifo #(.DATASIZE(8), .MEM_DEPTH(16), .ADDRSIZE(4), .AF_THRESH(12), .AE_THRESH(2)) dut16 (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_wr_en(wr), .i_wr_data(wd), .i_rd_en(rd),
    .o_rd_data(rdata[0]), .o_rd_valid(rvalid[0]), .o_full(full[0]), .o_empty(empty[0]),
    .o_afull(afull[0]), .o_aempty(aempty[0]), .o_count(cnt[0]), .o_ovf(ovf[0]), .o_udf(udf[0])
`ifdef SYNC_FIFO_PARITY_EN
    , .o_par_err(perr[0])
`endif
  );
  sync_fifo #(.DATASIZE(8), .MEM_DEPTH(10), .ADDRSIZE(4), .AF_THRESH(7), .AE_THRESH(2)) dut10 (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_wr_en(wr), .i_wr_data(wd), .i_rd_en(rd),
    .o_rd_data(rdata[1]), .o_rd_valid(rvalid[1]), .o_full(full[1]), .o_empty(empty[1]),
    .o_afull(afull[1]), .o_aempty(aempty[1]), .o_count(cnt[1]), .o_ovf(ovf[1]), .o_udf(udf[1])
`ifdef SYNC_FIFO_PARITY_EN
    , .o_par_err(perr[1])
`endif
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step(input bit w, input bit r, input logic [7:0] d, input bit c);
    wr = w; rd = r; wd = d; clr = c;
    @(posedge clk);
    @(negedge clk);
  endtask
  // queue model: occupancy is the queue size, flags are comparisons on it
  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      bit f, e;
      f = mq[k].size() == DEPTH[k];
      e = mq[k].size() == 0;
      if (rst) begin
        mq[k].delete(); m_data[k] = 0; m_valid[k] = 0; m_ovf[k] = 0; m_udf[k] = 0;
      end else if (clr) begin
        mq[k].delete(); m_valid[k] = 0; m_ovf[k] = 0; m_udf[k] = 0;
      end else begin
        if (wr && f) m_ovf[k] = 1;
        if (rd && e) m_udf[k] = 1;
        m_valid[k] = rd && !e;
        if (rd && !e) m_data[k] = mq[k].pop_front();
        if (wr && !f) mq[k].push_back(wd);
      end
    end
  end
  // compare every output of both instances against the model each cycle
  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        int n;
        n = mq[k].size();
        chk($sformatf("count_d%0d", DEPTH[k]), 32'(cnt[k]), 32'(n));
        chk($sformatf("full_d%0d", DEPTH[k]), 32'(full[k]), 32'(n == DEPTH[k]));
        chk($sformatf("empty_d%0d", DEPTH[k]), 32'(empty[k]), 32'(n == 0));
        chk($sformatf("afull_d%0d", DEPTH[k]), 32'(afull[k]), 32'(n >= AFTH[k]));
        chk($sformatf("aempty_d%0d", DEPTH[k]), 32'(aempty[k]), 32'(n <= AETH));
        chk($sformatf("ovf_d%0d", DEPTH[k]), 32'(ovf[k]), 32'(m_ovf[k]));
        chk($sformatf("udf_d%0d", DEPTH[k]), 32'(udf[k]), 32'(m_udf[k]));
        chk($sformatf("rvalid_d%0d", DEPTH[k]), 32'(rvalid[k]), 32'(m_valid[k]));
        chk($sformatf("rdata_d%0d", DEPTH[k]), 32'(rdata[k]), 32'(m_data[k]));
      end
    end
  end
  initial begin
    #1 rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    chk_on = 1;
    chk("rst_count", 32'(cnt[0]), 0);
    chk("rst_empty", 32'(empty[0]), 1);
    chk("rst_aempty", 32'(aempty[0]), 1);
    chk("rst_full", 32'(full[0]), 0);
    chk("rst_rdata", 32'(rdata[0]), 0);
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 8'(i), 0);
      chk("fill_count", 32'(cnt[0]), 32'(i + 1));
      chk("fill_afull", 32'(afull[0]), 32'(i >= 11));
    end
    chk("fill_full", 32'(full[0]), 1);
    step(1, 0, 8'hAA, 0);
    chk("ovf_set", 32'(ovf[0]), 1);
    chk("ovf_count", 32'(cnt[0]), 16);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 8'h00, 0);
      chk("drain_valid", 32'(rvalid[0]), 1);
      chk("drain_data", 32'(rdata[0]), 32'(i));
      chk("drain_aempty", 32'(aempty[0]), 32'(15 - i <= 2));
    end
    chk("drain_empty", 32'(empty[0]), 1);
    step(0, 0, 8'h00, 0);
    chk("hold_data", 32'(rdata[0]), 32'h0F);
    chk("hold_valid", 32'(rvalid[0]), 0);
    step(0, 1, 8'h00, 0);
    chk("udf_valid", 32'(rvalid[0]), 0);
    chk("udf_set", 32'(udf[0]), 1);
    step(1, 1, 8'h55, 0);
    chk("wr_rd_empty_count", 32'(cnt[0]), 1);
    chk("wr_rd_empty_valid", 32'(rvalid[0]), 0);
    for (int i = 0; i < 4; i++) step(1, 0, 8'(8'h60 + i), 0);
    step(1, 1, 8'h70, 0);
    chk("wr_rd_5_count", 32'(cnt[0]), 5);
    chk("wr_rd_5_data", 32'(rdata[0]), 32'h55);
    step(1, 0, 8'h71, 0);
    step(1, 0, 8'h72, 0);
    chk("pre_clr_count", 32'(cnt[0]), 7);
    step(1, 1, 8'h99, 1);
    chk("clr_count", 32'(cnt[0]), 0);
    chk("clr_empty", 32'(empty[0]), 1);
    chk("clr_ovf", 32'(ovf[0]), 0);
    chk("clr_udf", 32'(udf[0]), 0);
    chk("clr_valid", 32'(rvalid[0]), 0);
    for (int b = 0; b < 8; b++) begin
      int pw, pr;
      pw = $urandom_range(20, 80);
      pr = $urandom_range(20, 80);
      for (int i = 0; i < 100; i++)
        step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, 8'($urandom), $urandom_range(0, 63) == 0);
    end
    for (int i = 0; i < 6; i++) step(1, i[0], 8'($urandom), 0);
    wr = 1; rd = 1;
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("arst_count", 32'(cnt[0]), 0);
    chk("arst_empty", 32'(empty[0]), 1);
    chk("arst_full", 32'(full[0]), 0);
    chk("arst_valid", 32'(rvalid[0]), 0);
    chk("arst_rdata", 32'(rdata[0]), 0);
    chk("arst_count10", 32'(cnt[1]), 0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 200; i++) step($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, 8'($urandom), 0);
`ifdef SYNC_FIFO_PARITY_EN
    step(0, 0, 8'h00, 1);
    step(1, 0, 8'h3C, 0);
    step(1, 0, 8'h3D, 0);
    dut16.u_ram.mem_q[0][8] = ~dut16.u_ram.mem_q[0][8];
    step(0, 1, 8'h00, 0);
    chk("par_err_hit", 32'(perr[0]), 1);
    chk("par_err_other", 32'(perr[1]), 0);
    step(0, 1, 8'h00, 0);
    chk("par_err_clean", 32'(perr[0]), 0);
`endif
    chk_on = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
